// File: rtl/bit_count_pkg.sv
// -----------------------------------------------------------------------------
// bit_count_pkg
// Shared types and constants for the bit-count result capture block:
//   count_t      - 4-bit bit-count value as produced by the datapath
//   ptr_t        - FIFO read/write pointer (wraps 3 -> 0)
//   level_t      - FIFO occupancy, 0..FIFO_DEPTH
//   SEG_*        - active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
//   ptr_inc()    - wrapping pointer increment
// -----------------------------------------------------------------------------
package bit_count_pkg;

    typedef logic [3:0] count_t;
    typedef logic [1:0] ptr_t;
    typedef logic [2:0] level_t;

    localparam int FIFO_DEPTH = 4;

    // Occupancy value that means "every slot holds an entry".
    localparam level_t LEVEL_FULL = 3'd4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;

    // Two-bit pointers wrap naturally from 3 back to 0.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return p + 2'd1;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational hex-digit to active-low 7-segment decoder.
// Ports:
//   digit [3:0] in  - value 0..F to display
//   seg   [6:0] out - active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg7_decode
    import bit_count_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Digit-to-segment lookup; all sixteen codes map to a hex glyph.
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bit_count_result_capture.sv
// -----------------------------------------------------------------------------
// bit_count_result_capture
// Captures each completed bit-count result (rising edge of done) into a
// 4-entry FIFO, flags dropped captures, and drives two 7-segment displays.
// Ports:
//   clk            in   system clock
//   reset_n        in   asynchronous active-low reset
//   done           in   datapath completion level
//   result   [3:0] in   datapath bit-count, valid while done=1
//   clear          in   synchronous flush of FIFO and overflow flag
//   out_ready      in   consumer accepts head entry this cycle
//   out_valid      out  FIFO non-empty
//   out_count[3:0] out  head-of-FIFO value (0 when empty)
//   fill_level[2:0]out  stored entries, 0..4
//   overflow       out  sticky: a capture was dropped because FIFO was full
//   hex0     [6:0] out  active-low image of the last captured result
//   hex1     [6:0] out  active-low image of fill_level
// -----------------------------------------------------------------------------
module bit_count_result_capture
    import bit_count_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         done,
    input  logic [3:0]   result,
    input  logic         clear,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [3:0]   out_count,
    output logic [2:0]   fill_level,
    output logic         overflow,
    output logic [6:0]   hex0,
    output logic [6:0]   hex1
);

    // Control state (reset) and storage (not reset).
    logic         done_q_r;
    ptr_t         wr_ptr_r;
    ptr_t         rd_ptr_r;
    level_t       fill_r;
    logic         overflow_r;
    logic [6:0]   hex0_r;
    logic [6:0]   hex1_r;
    count_t       mem_r [FIFO_DEPTH];

    logic         capture_s;
    logic         empty_s;
    logic         full_s;
    logic         pop_s;
    logic         push_s;
    logic         drop_s;
    level_t       fill_next_s;
    logic [6:0]   result_seg_s;
    logic [6:0]   fill_seg_s;

    // Capture-event detection and FIFO handshake decisions.
    always_comb begin
        capture_s = done & ~done_q_r;
        empty_s   = (fill_r == 3'd0);
        full_s    = (fill_r == LEVEL_FULL);
        // A pop on an empty FIFO is meaningless, so out_ready is masked.
        pop_s     = ~empty_s & out_ready;
        // When full, a same-cycle pop frees the slot the push needs.
        push_s    = capture_s & (~full_s | pop_s);
        drop_s    = capture_s & full_s & ~pop_s;
    end

    // Next occupancy; clear overrides any push/pop in the same cycle.
    always_comb begin
        fill_next_s = fill_r;
        if (clear) begin
            fill_next_s = 3'd0;
        end else if (push_s && !pop_s) begin
            fill_next_s = fill_r + 3'd1;
        end else if (pop_s && !push_s) begin
            fill_next_s = fill_r - 3'd1;
        end else begin
            fill_next_s = fill_r;
        end
    end

    // hex0 follows the incoming result; hex1 follows the next fill level so
    // the registered image lines up with the registered fill_level.
    seg7_decode u_seg_result (
        .digit (result),
        .seg   (result_seg_s)
    );

    seg7_decode u_seg_fill (
        .digit ({1'b0, fill_next_s}),
        .seg   (fill_seg_s)
    );

    // FIFO storage write; contents are don't-care until pointed at by rd_ptr.
    always_ff @(posedge clk) begin
        if (push_s && !clear) begin
            mem_r[wr_ptr_r] <= result;
        end
    end

    // FIFO control, overflow flag, edge-detect register and display registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q_r   <= 1'b0;
            wr_ptr_r   <= 2'd0;
            rd_ptr_r   <= 2'd0;
            fill_r     <= 3'd0;
            overflow_r <= 1'b0;
            hex0_r     <= SEG_BLANK;
            hex1_r     <= SEG_0;
        end else begin
            done_q_r <= done;
            fill_r   <= fill_next_s;
            hex1_r   <= fill_seg_s;
            if (clear) begin
                wr_ptr_r   <= 2'd0;
                rd_ptr_r   <= 2'd0;
                overflow_r <= 1'b0;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= ptr_inc(wr_ptr_r);
                end
                if (pop_s) begin
                    rd_ptr_r <= ptr_inc(rd_ptr_r);
                end
                if (drop_s) begin
                    overflow_r <= 1'b1;
                end
                // Dropped captures still update the display.
                if (capture_s) begin
                    hex0_r <= result_seg_s;
                end
            end
        end
    end

    // Head is forced to zero when empty so reset shows out_count=0 without
    // needing to reset the storage array.
    always_comb begin
        out_valid  = ~empty_s;
        fill_level = fill_r;
        overflow   = overflow_r;
        hex0       = hex0_r;
        hex1       = hex1_r;
        if (empty_s) begin
            out_count = 4'd0;
        end else begin
            out_count = mem_r[rd_ptr_r];
        end
    end

endmodule

// File: tb/tb_bit_count_result_capture.sv
// -----------------------------------------------------------------------------
// tb_bit_count_result_capture
// Directed stimulus with a scoreboard queue: stimulus pushes the value it
// expects to be stored, a negedge monitor compares the FIFO head and pops the
// queue whenever the DUT hands an entry to the consumer.
// -----------------------------------------------------------------------------
module tb_bit_count_result_capture;

    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_0     = 7'b1000000;
    localparam logic [6:0] S_1     = 7'b1111001;
    localparam logic [6:0] S_3     = 7'b0110000;
    localparam logic [6:0] S_4     = 7'b0011001;
    localparam logic [6:0] S_5     = 7'b0010010;
    localparam logic [6:0] S_6     = 7'b0000010;
    localparam logic [6:0] S_8     = 7'b0000000;
    localparam logic [6:0] S_B     = 7'b0000011;

    logic       clk;
    logic       reset_n;
    logic       done;
    logic [3:0] result;
    logic       clear;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_count;
    logic [2:0] fill_level;
    logic       overflow;
    logic [6:0] hex0;
    logic [6:0] hex1;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];

    bit_count_result_capture dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .done       (done),
        .result     (result),
        .clear      (clear),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_count  (out_count),
        .fill_level (fill_level),
        .overflow   (overflow),
        .hex0       (hex0),
        .hex1       (hex1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One capture event followed by one low cycle of done.
    task automatic capture(input logic [3:0] v, input bit store);
        done   = 1'b1;
        result = v;
        tick();
        if (store) exp_q.push_back(v);
        done   = 1'b0;
        result = 4'd0;
        tick();
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) tick();
        out_ready = 1'b0;
    endtask

    // Monitor: head must match the scoreboard; accepted entries are retired.
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL head_unexpected: got out_count %0d expected no entry", out_count);
            end else begin
                chk("head", int'(out_count), int'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        done      = 1'b0;
        result    = 4'd0;
        clear     = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_count", int'(out_count), 0);
        chk("rst_fill", int'(fill_level), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_hex0", int'(hex0), int'(S_BLANK));
        chk("rst_hex1", int'(hex1), int'(S_0));
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Single capture of 3
        capture(4'd3, 1'b1);
        chk("c3_valid", int'(out_valid), 1);
        chk("c3_fill", int'(fill_level), 1);
        chk("c3_hex0", int'(hex0), int'(S_3));
        chk("c3_hex1", int'(hex1), int'(S_1));
        drain(1);
        chk("c3_drained", int'(fill_level), 0);

        // done held high for 10 cycles -> one entry
        done   = 1'b1;
        result = 4'd5;
        tick();
        exp_q.push_back(4'd5);
        repeat (9) tick();
        chk("hold_fill", int'(fill_level), 1);
        done = 1'b0;
        tick();
        chk("hold_fill_after", int'(fill_level), 1);
        drain(1);

        // Five captures, fifth dropped
        for (int v = 1; v <= 5; v++) capture(4'(v), v <= 4);
        chk("ovf_fill", int'(fill_level), 4);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_hex0", int'(hex0), int'(S_5));
        chk("ovf_hex1", int'(hex1), int'(S_4));
        drain(4);
        chk("ovf_drained", int'(fill_level), 0);
        chk("ovf_sticky", int'(overflow), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_ovf", int'(overflow), 0);
        chk("clr_hex0_kept", int'(hex0), int'(S_5));

        // Full FIFO with simultaneous push and pop
        for (int v = 1; v <= 4; v++) capture(4'(v), 1'b1);
        done      = 1'b1;
        result    = 4'd5;
        out_ready = 1'b1;
        tick();
        exp_q.push_back(4'd5);
        done      = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("fullpp_fill", int'(fill_level), 4);
        chk("fullpp_ovf", int'(overflow), 0);

        // Drop 6, leave two entries, then clear with a same-cycle capture
        capture(4'd6, 1'b0);
        chk("drop6_ovf", int'(overflow), 1);
        chk("drop6_hex0", int'(hex0), int'(S_6));
        drain(2);
        chk("two_fill", int'(fill_level), 2);
        clear  = 1'b1;
        done   = 1'b1;
        result = 4'd9;
        tick();
        exp_q.delete();
        clear  = 1'b0;
        done   = 1'b0;
        result = 4'd0;
        tick();
        chk("clrcap_fill", int'(fill_level), 0);
        chk("clrcap_valid", int'(out_valid), 0);
        chk("clrcap_ovf", int'(overflow), 0);
        chk("clrcap_hex0", int'(hex0), int'(S_6));
        chk("clrcap_hex1", int'(hex1), int'(S_0));

        // Push into empty FIFO while out_ready is already high
        out_ready = 1'b1;
        done      = 1'b1;
        result    = 4'd7;
        tick();
        exp_q.push_back(4'd7);
        chk("emptypush_fill", int'(fill_level), 1);
        done = 1'b0;
        tick();
        chk("emptypush_popped", int'(fill_level), 0);
        out_ready = 1'b0;

        // Hex letter display
        capture(4'hB, 1'b1);
        chk("hexB", int'(hex0), int'(S_B));
        drain(1);

        // Asynchronous reset mid-cycle with three entries
        for (int v = 1; v <= 3; v++) capture(4'(v), 1'b1);
        chk("pre_rst_fill", int'(fill_level), 3);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_fill", int'(fill_level), 0);
        chk("arst_count", int'(out_count), 0);
        chk("arst_hex0", int'(hex0), int'(S_BLANK));
        chk("arst_hex1", int'(hex1), int'(S_0));

        // done already high at reset release is captured on the first edge
        done   = 1'b1;
        result = 4'd8;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        exp_q.push_back(4'd8);
        chk("rel_fill", int'(fill_level), 1);
        chk("rel_hex0", int'(hex0), int'(S_8));
        done = 1'b0;
        drain(1);
        chk("rel_drained", int'(fill_level), 0);

        tick();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
